xc_aesmix_multi: RTL and testbench



---
 rtl/xc_aesmix_pkg.sv | 37 +++
 rtl/xc_aesmix_if.sv | 29 ++
 rtl/xc_aesmix_byte.sv | 46 ++++
 rtl/xc_aesmix_multi.sv | 120 ++++++++++++
 tb/tb_xc_aesmix_multi.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/xc_aesmix_pkg.sv
// xc_aesmix_pkg: shared types, constants and GF(2^8) helpers for the multi-cycle
// AES MixColumns / InvMixColumns unit.
//   state_e            FSM state encoding (StIdle, StBusy, StDone)
//   COEF_ENC/COEF_DEC  column coefficients, indexed by (j - i) mod 4
//   gf_xtime           multiply by x modulo 0x11b
//   gf_mul             byte times 4-bit constant modulo 0x11b
package xc_aesmix_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [3:0] COEF_ENC [4] = '{4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [3:0] COEF_DEC [4] = '{4'he, 4'hb, 4'hd, 4'h9};

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add over the four coefficient bits; only nibble constants are needed.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                acc = acc ^ p;
            end
            p = gf_xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/xc_aesmix_if.sv
// xc_aesmix_if: request/response bundle between the execute stage and the mix unit.
//   flush, flush_data   abort and load flush_data into the result register
//   valid               request, held until ready
//   rs1, rs2, enc       operands (b0 = rs1[7:0], b1 = rs1[15:8], b2 = rs2[23:16],
//                       b3 = rs2[31:24]) and direction (1 = MixColumns)
//   ready, result       one-cycle completion pulse and registered column result
// modport master: requester side; modport slave: the mix unit.
interface xc_aesmix_if;

    logic        flush;
    logic [31:0] flush_data;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] result;

    modport master (
        output flush, flush_data, valid, rs1, rs2, enc,
        input  ready, result
    );

    modport slave (
        input  flush, flush_data, valid, rs1, rs2, enc,
        output ready, result
    );

endinterface

// File: rtl/xc_aesmix_byte.sv
// xc_aesmix_byte: combinational computation of one output byte of a (Inv)MixColumns
// column: out = XOR_j coef[(j - row) mod 4] * b_j.
//   col_i   four column bytes, col_i[j] = b_j
//   row_i   output byte index 0..3
//   enc_i   1 = MixColumns, 0 = InvMixColumns
//   byte_o  resulting byte
// Build option XC_AESMIX_DEC_EN: when undefined the inverse multipliers are absent and an
// enc_i = 0 request yields 8'h00.
module xc_aesmix_byte
    import xc_aesmix_pkg::*;
(
    input  logic [3:0][7:0] col_i,
    input  logic [1:0]      row_i,
    input  logic            enc_i,
    output logic [7:0]      byte_o
);

    logic [7:0] enc_acc;
    logic [1:0] sel;
`ifdef XC_AESMIX_DEC_EN
    logic [7:0] dec_acc;
`endif

    always_comb begin
        enc_acc = 8'h00;
        sel     = 2'd0;
`ifdef XC_AESMIX_DEC_EN
        dec_acc = 8'h00;
`endif
        for (int j = 0; j < 4; j++) begin
            // Two-bit wrap gives the mod-4 coefficient rotation for free.
            sel     = 2'(j) - row_i;
            enc_acc = enc_acc ^ gf_mul(col_i[j], COEF_ENC[sel]);
`ifdef XC_AESMIX_DEC_EN
            dec_acc = dec_acc ^ gf_mul(col_i[j], COEF_DEC[sel]);
`endif
        end
    end

`ifdef XC_AESMIX_DEC_EN
    assign byte_o = enc_i ? enc_acc : dec_acc;
`else
    assign byte_o = enc_i ? enc_acc : 8'h00;
`endif

endmodule

// File: rtl/xc_aesmix_multi.sv
// xc_aesmix_multi: multi-cycle AES MixColumns / InvMixColumns unit producing LANES output
// bytes per cycle (LANES = 1, 2 or 4), so a column takes 4/LANES busy cycles.
//   clk_i    system clock
//   rst_i    synchronous, active-high reset
//   bus_io   xc_aesmix_if.slave: flush/flush_data, valid, rs1, rs2, enc in; ready, result out
// Priority: reset > flush > abort (valid low while busy) > normal operation.
// Build option XC_AESMIX_DEC_EN enables InvMixColumns (enc = 0); without it such a request
// runs with full latency and returns 32'h0.
module xc_aesmix_multi
    import xc_aesmix_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    xc_aesmix_if.slave   bus_io
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("xc_aesmix_multi: LANES must be 1, 2 or 4");
    end

    localparam logic [2:0] LanesW = 3'(LANES);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] col_q, col_d;
    logic            enc_q, enc_d;
    logic [3:0][7:0] result_q, result_d;
    logic            ready_q, ready_d;
    logic [2:0]      idx_next;

    logic [1:0]      lane_row [LANES];
    logic [7:0]      lane_out [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_row[k] = idx_q + 2'(k);

        xc_aesmix_byte u_byte (
            .col_i  (col_q),
            .row_i  (lane_row[k]),
            .enc_i  (enc_q),
            .byte_o (lane_out[k])
        );
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        col_d    = col_q;
        enc_d    = enc_q;
        result_d = result_q;
        idx_next = {1'b0, idx_q} + LanesW;

        if (bus_io.flush) begin
            state_d  = StIdle;
            idx_d    = 2'd0;
            result_d = bus_io.flush_data;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.valid) begin
                        state_d  = StBusy;
                        col_d    = {bus_io.rs2[31:24], bus_io.rs2[23:16],
                                    bus_io.rs1[15:8],  bus_io.rs1[7:0]};
                        enc_d    = bus_io.enc;
                        idx_d    = 2'd0;
                        result_d = '0;
                    end
                end
                StBusy: begin
                    if (!bus_io.valid) begin
                        // Requester withdrew: drop the partial result, never pulse ready.
                        state_d  = StIdle;
                        idx_d    = 2'd0;
                        result_d = '0;
                    end else begin
                        for (int k = 0; k < LANES; k++) begin
                            result_d[lane_row[k]] = lane_out[k];
                        end
                        idx_d = idx_next[1:0];
                        if (idx_next == 3'd4) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        ready_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            col_q    <= '0;
            enc_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            col_q    <= col_d;
            enc_q    <= enc_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus_io.ready  = ready_q;
    assign bus_io.result = result_q;

endmodule

// File: tb/tb_xc_aesmix_multi.sv
// tb_xc_aesmix_multi: drives three instances (LANES = 1, 2, 4) from a shared vector table
// and checks result, ready timing and the abort / flush / back-to-back corner cases.
module tb_xc_aesmix_multi;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_data;
    logic [2:0]  valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic [2:0]  rdy;
    logic [31:0] res [3];

    int checks   = 0;
    int failures = 0;

    localparam int LatTab   [3] = '{5, 3, 2};
    localparam int LanesTab [3] = '{1, 2, 4};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        xc_aesmix_if bus ();

        assign bus.flush      = flush;
        assign bus.flush_data = flush_data;
        assign bus.valid      = valid[g];
        assign bus.rs1        = rs1;
        assign bus.rs2        = rs2;
        assign bus.enc        = enc;
        assign rdy[g]         = bus.ready;
        assign res[g]         = bus.result;

        xc_aesmix_multi #(.LANES(L)) dut (
            .clk_i  (clk),
            .rst_i  (rst),
            .bus_io (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at the negedge of cycle 0; watches cycles 1..8 for every active instance.
    task automatic wait_done(input logic [2:0] act, input logic [31:0] exp, input string name);
        int seen   [3];
        int pulses [3];
        for (int k = 0; k < 3; k++) begin
            seen[k]   = -1;
            pulses[k] = 0;
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (act[k] && rdy[k]) begin
                    pulses[k]++;
                    if (seen[k] < 0) begin
                        seen[k] = c;
                        chk($sformatf("%s_L%0d_result", name, LanesTab[k]), res[k], exp);
                    end
                    valid[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (act[k]) begin
                chk($sformatf("%s_L%0d_pulses", name, LanesTab[k]), 32'(pulses[k]), 32'd1);
                chk($sformatf("%s_L%0d_latency", name, LanesTab[k]), 32'(seen[k]),
                    32'(LatTab[k]));
            end
        end
        valid = valid & ~act;
    endtask

    task automatic run_op(input logic [2:0] act, input logic [31:0] r1, input logic [31:0] r2,
                          input logic e, input logic [31:0] exp, input string name);
        @(negedge clk);
        rs1   = r1;
        rs2   = r2;
        enc   = e;
        valid = act;
        wait_done(act, exp, name);
    endtask

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        enc;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int pulses;
        int first;
        int second;

        vecs[0] = '{32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e, "enc_v1"};
        vecs[1] = '{32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f, "enc_v2"};
        vecs[2] = '{32'h00000101, 32'h01010000, 1'b1, 32'h01010101, "enc_ident"};
`ifdef XC_AESMIX_DEC_EN
        vecs[3] = '{32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db, "dec_v1"};
        vecs[4] = '{32'h00000101, 32'h01010000, 1'b0, 32'h01010101, "dec_ident"};
`else
        vecs[3] = '{32'h00004d8e, 32'hbca10000, 1'b0, 32'h00000000, "dec_v1"};
        vecs[4] = '{32'h00000101, 32'h01010000, 1'b0, 32'h00000000, "dec_ident"};
`endif

        // Reset held two cycles with a pending request.
        rst        = 1'b1;
        flush      = 1'b0;
        flush_data = 32'h0;
        valid      = 3'b111;
        rs1        = vecs[0].rs1;
        rs2        = vecs[0].rs2;
        enc        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_L%0d_ready", LanesTab[k]), 32'(rdy[k]), 32'd0);
            chk($sformatf("reset_L%0d_result", LanesTab[k]), res[k], 32'h0);
        end
        rst = 1'b0;
        wait_done(3'b111, vecs[0].exp, "after_reset");

        for (int i = 0; i < 5; i++) begin
            run_op(3'b111, vecs[i].rs1, vecs[i].rs2, vecs[i].enc, vecs[i].exp, vecs[i].name);
        end

        // Abort: valid dropped in cycle 2 on the LANES=1 instance.
        @(negedge clk);
        rs1      = vecs[0].rs1;
        rs2      = vecs[0].rs2;
        enc      = 1'b1;
        valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        pulses   = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rdy[0]) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_result", res[0], 32'h0);

        // Flush during BUSY.
        @(negedge clk);
        valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush      = 1'b1;
        flush_data = 32'hdeadbeef;
        valid[0]   = 1'b0;
        @(negedge clk);
        flush  = 1'b0;
        chk("flush_busy_result", res[0], 32'hdeadbeef);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (rdy[0]) pulses++;
            @(negedge clk);
        end
        chk("flush_busy_pulses", 32'(pulses), 32'd0);
        chk("flush_busy_hold", res[0], 32'hdeadbeef);
        run_op(3'b001, vecs[1].rs1, vecs[1].rs2, 1'b1, vecs[1].exp, "after_flush");

        // Flush beats a request in IDLE.
        @(negedge clk);
        valid[0]   = 1'b1;
        flush      = 1'b1;
        flush_data = 32'h12345678;
        @(negedge clk);
        flush    = 1'b0;
        valid[0] = 1'b0;
        pulses   = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[0]) pulses++;
        end
        chk("flush_idle_result", res[0], 32'h12345678);
        chk("flush_idle_pulses", 32'(pulses), 32'd0);

        // Back-to-back on LANES=1: valid held through ready, operands swapped at ready,
        // then scrambled mid-operation (must be ignored).
        @(negedge clk);
        rs1      = vecs[0].rs1;
        rs2      = vecs[0].rs2;
        enc      = 1'b1;
        valid[0] = 1'b1;
        first    = -1;
        second   = -1;
        pulses   = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 8) begin
                rs1 = 32'h0;
                rs2 = 32'h0;
            end
            if (rdy[0]) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    chk("b2b_first_result", res[0], vecs[0].exp);
                    rs1 = vecs[1].rs1;
                    rs2 = vecs[1].rs2;
                end else if (second < 0) begin
                    second = c;
                    chk("b2b_second_result", res[0], vecs[1].exp);
                    valid[0] = 1'b0;
                end
            end
        end
        valid[0] = 1'b0;
        chk("b2b_first_cycle", 32'(first), 32'd5);
        chk("b2b_second_cycle", 32'(second), 32'd11);
        chk("b2b_pulses", 32'(pulses), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
